scaler_line_writer: RTL and testbench
=====================================

SCALER_LINE_WRITER -- requirements
Module: scaler_line_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, giving the line-buffer RAM address width (MSB selects the bank).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the pixel width.
REQ-003 The block SHALL have a single clock: clk, input, 1 bit, rising-edge clock for all logic; no other clock is used.
REQ-004 The block SHALL have rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 The block SHALL have s_valid, input, 1 bit, meaning an upstream pixel is present.
REQ-006 The block SHALL have s_ready, output, 1 bit, meaning the block accepts the pixel this cycle.
REQ-007 The block SHALL have s_data, input, DATA_WIDTH bits, carrying the pixel value.
REQ-008 The block SHALL have s_last, input, 1 bit, marking the last pixel of a line.
REQ-009 The block SHALL have ram_addr, output, ADDR_WIDTH bits, carrying the RAM port-A address.
REQ-010 The block SHALL have ram_wr_data, output, DATA_WIDTH bits, carrying the RAM port-A write data.
REQ-011 The block SHALL have ram_wr_en, output, 1 bit, the RAM port-A write strobe.
REQ-012 The block SHALL have line_valid, output, 1 bit, meaning a completed line is available downstream.
REQ-013 The block SHALL have line_bank, output, 1 bit, giving the bank of the presented line.
REQ-014 The block SHALL have line_len, output, ADDR_WIDTH bits, giving the pixel count of the presented line (1..2^(ADDR_WIDTH-1)).
REQ-015 The block SHALL have line_rel, input, 1 bit, a downstream pulse that releases the presented bank.
REQ-016 The block SHALL have ovf_err, output, 1 bit, a sticky flag set when a line exceeds bank capacity.

Function
REQ-017 The RAM SHALL be split into two banks of BANK=2^(ADDR_WIDTH-1) entries; bank = address MSB, column = lower bits.
REQ-018 A pixel SHALL be accepted on a cycle with s_valid and s_ready both high.
REQ-019 The block SHALL register the write for each accepted pixel in FILL, one cycle after acceptance: ram_wr_en=1, ram_addr={wbank,col}, ram_wr_data=s_data.
REQ-020 The FSM SHALL have exactly three states: FILL, DROP and STALL.
REQ-021 In FILL, s_ready SHALL be 1; col SHALL increment per accepted pixel.
REQ-022 In FILL, an accepted pixel with s_last=1 SHALL close the line: len[wbank]=col+1, full[wbank]=1, wbank toggles, col=0, next state FILL if full[new wbank]=0, else STALL.
REQ-023 In FILL, an accepted pixel with col=BANK-1 and s_last=0 SHALL close the line with len=BANK, set ovf_err, toggle wbank and col=0, with next state DROP.
REQ-024 In DROP, s_ready SHALL be 1, accepted pixels SHALL NOT be written, and an accepted s_last SHALL cause exit to FILL or STALL by the same full[wbank] test.
REQ-025 In STALL, s_ready SHALL be 0; the block SHALL leave STALL for FILL the cycle after full[wbank] clears.
REQ-026 The ready rule SHALL hold: s_ready is combinational from state only and SHALL NOT depend on s_valid.
REQ-027 line_valid SHALL equal full[rbank]; line_bank SHALL equal rbank; line_len SHALL equal len[rbank].
REQ-028 line_rel with line_valid=1 SHALL clear full[rbank] and toggle rbank next cycle.
REQ-029 line_rel with line_valid=0 SHALL be ignored.
REQ-030 A line completion and a release of the other bank in the same cycle SHALL both take effect.
REQ-031 A release of the bank STALL is waiting on SHALL make s_ready=1 two cycles after line_rel.
REQ-032 Lines SHALL be presented in completion order; at most two lines SHALL be pending.

Reset
REQ-033 While rst=1: state=FILL, wbank=0, rbank=0, col=0, full=00, ovf_err=0, ram_wr_en=0, s_ready=0, line_valid=0; line_len and ram_addr SHALL be 0.
REQ-034 A reset mid-line SHALL discard the partial line and both pending lines; no write SHALL be issued in the cycle after rst deasserts.
REQ-035 s_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-036 Accept 4 pixels 0x10..0x13, last on 0x13 -> writes at addr 0..3, then line_valid=1, line_bank=0, line_len=4.
REQ-037 Two lines of lengths 3 and 5 with no release -> s_ready=0 (STALL); line_rel -> line_bank=1, line_len=5, and s_ready=1 two cycles later.
REQ-038 With ADDR_WIDTH=11, a line of 1030 pixels -> 1024 writes to addr 0..1023, line_len=1024, ovf_err=1, no writes for pixels 1025..1030, and the next line writes from addr 1024.
REQ-039 line_rel pulsed with line_valid=0 -> no state change.
REQ-040 Last pixel of bank 1 accepted in the same cycle as line_rel of bank 0 -> full=10 then rbank=1, and no stall.
REQ-041 rst asserted mid-line after 7 pixels -> line_valid=0, ovf_err=0, and the next pixel writes to addr 0.

Source files
------------

// File: rtl/scaler_line_writer_if.sv
// Pixel-stream / line-buffer port bundle for scaler_line_writer.
//   s_valid, s_ready, s_data, s_last : upstream pixel stream handshake
//   ram_addr, ram_wr_data, ram_wr_en : line-buffer RAM port-A write side
//   line_valid, line_bank, line_len  : completed-line presentation downstream
//   line_rel                         : downstream release pulse for the presented bank
//   ovf_err                          : sticky line-overflow flag
// Modport slave is the writer block; modport master is whoever drives the stream
// and consumes lines.
interface scaler_line_writer_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic                  line_valid;
    logic                  line_bank;
    logic [ADDR_WIDTH-1:0] line_len;
    logic                  line_rel;
    logic                  ovf_err;

    modport slave (
        input  s_valid, s_data, s_last, line_rel,
        output s_ready, ram_addr, ram_wr_data, ram_wr_en,
        output line_valid, line_bank, line_len, ovf_err
    );

    modport master (
        output s_valid, s_data, s_last, line_rel,
        input  s_ready, ram_addr, ram_wr_data, ram_wr_en,
        input  line_valid, line_bank, line_len, ovf_err
    );
endinterface

// File: rtl/scaler_line_writer.sv
// Double-banked line writer for a scaler line buffer.
// Incoming pixels are written into one of two RAM banks (bank = address MSB).
// A line closes on s_last, or forcibly when the bank fills (overflow: the rest
// of that line is dropped and ovf_err latches). Closed lines are presented in
// completion order until the consumer releases them with line_rel.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : scaler_line_writer_if.slave (stream in, RAM write out, line handoff)
module scaler_line_writer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    scaler_line_writer_if.slave    bus
);
    localparam int COL_W = ADDR_WIDTH - 1;
    localparam logic [COL_W-1:0]      COL_MAX  = {COL_W{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] BANK_LEN = {1'b1, {COL_W{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ONE_LEN  = {{COL_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DROP  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                         state_r, state_nxt_s;
    logic                           wbank_r, wbank_nxt_s;
    logic                           rbank_r, rbank_nxt_s;
    logic [COL_W-1:0]               col_r, col_nxt_s;
    logic [1:0]                     full_r, full_nxt_s;
    logic [1:0][ADDR_WIDTH-1:0]     len_r, len_nxt_s;
    logic                           ovf_err_r, ovf_set_s;
    logic                           wr_en_r, wr_en_nxt_s;
    logic [ADDR_WIDTH-1:0]          wr_addr_r;
    logic [DATA_WIDTH-1:0]          wr_data_r;
    logic                           ready_s;
    logic                           accept_s;
    logic                           rel_fire_s;

    // Ready depends only on the FSM state (held low during reset).
    assign ready_s    = ~rst & (state_r != ST_STALL);
    assign accept_s   = bus.s_valid & ready_s;
    assign rel_fire_s = bus.line_rel & full_r[rbank_r];

    // Next-state logic: release of the presented bank, pixel accounting and line closing.
    always_comb begin
        state_nxt_s = state_r;
        wbank_nxt_s = wbank_r;
        rbank_nxt_s = rbank_r;
        col_nxt_s   = col_r;
        full_nxt_s  = full_r;
        len_nxt_s   = len_r;
        ovf_set_s   = 1'b0;
        wr_en_nxt_s = 1'b0;

        // Release is applied first so a line closing this same cycle sees the
        // freed bank and does not stall needlessly.
        if (rel_fire_s) begin
            full_nxt_s[rbank_r] = 1'b0;
            rbank_nxt_s         = ~rbank_r;
        end else begin
            rbank_nxt_s = rbank_r;
        end

        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    wr_en_nxt_s = 1'b1;
                    if (bus.s_last) begin
                        len_nxt_s[wbank_r]  = {1'b0, col_r} + ONE_LEN;
                        full_nxt_s[wbank_r] = 1'b1;
                        wbank_nxt_s         = ~wbank_r;
                        col_nxt_s           = {COL_W{1'b0}};
                        state_nxt_s         = full_nxt_s[~wbank_r] ? ST_STALL : ST_FILL;
                    end else if (col_r == COL_MAX) begin
                        // Bank is full but the line goes on: close it at
                        // capacity and discard pixels up to s_last.
                        len_nxt_s[wbank_r]  = BANK_LEN;
                        full_nxt_s[wbank_r] = 1'b1;
                        wbank_nxt_s         = ~wbank_r;
                        col_nxt_s           = {COL_W{1'b0}};
                        ovf_set_s           = 1'b1;
                        state_nxt_s         = ST_DROP;
                    end else begin
                        col_nxt_s = col_r + {{(COL_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DROP: begin
                if (accept_s && bus.s_last) begin
                    state_nxt_s = full_nxt_s[wbank_r] ? ST_STALL : ST_FILL;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_STALL: begin
                if (!full_r[wbank_r]) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State, bank bookkeeping and registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FILL;
            wbank_r   <= 1'b0;
            rbank_r   <= 1'b0;
            col_r     <= {COL_W{1'b0}};
            full_r    <= 2'b00;
            len_r     <= {(2*ADDR_WIDTH){1'b0}};
            ovf_err_r <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            wbank_r   <= wbank_nxt_s;
            rbank_r   <= rbank_nxt_s;
            col_r     <= col_nxt_s;
            full_r    <= full_nxt_s;
            len_r     <= len_nxt_s;
            ovf_err_r <= ovf_err_r | ovf_set_s;
            wr_en_r   <= wr_en_nxt_s;
            if (wr_en_nxt_s) begin
                wr_addr_r <= {wbank_r, col_r};
                wr_data_r <= bus.s_data;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign bus.s_ready     = ready_s;
    assign bus.ram_addr    = wr_addr_r;
    assign bus.ram_wr_data = wr_data_r;
    assign bus.ram_wr_en   = wr_en_r;
    assign bus.line_valid  = full_r[rbank_r];
    assign bus.line_bank   = rbank_r;
    assign bus.line_len    = len_r[rbank_r];
    assign bus.ovf_err     = ovf_err_r;
endmodule

// File: tb/tb_scaler_line_writer.sv
// Self-checking bench for scaler_line_writer: directed scenarios plus random
// traffic, compared against a line-level reference model with a write scoreboard.
module tb_scaler_line_writer;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int CW   = AW - 1;
    localparam int BANK = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scaler_line_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    scaler_line_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int bank; int len;  } line_t;

    wr_t   exp_wr[$];
    line_t pend[$];
    int    checks   = 0;
    int    failures = 0;

    // reference model state
    int m_wbank, m_rbank, m_col, m_drop, m_stall, m_cnt, m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit occupied(input int b);
        foreach (pend[i]) if (pend[i].bank == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_wbank = 0; m_rbank = 0; m_col = 0; m_drop = 0;
        m_stall = 0; m_cnt = 0; m_ovf = 0;
        pend.delete();
    endtask

    // Write monitor: each DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.ram_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", int'(bus.ram_addr), -1);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("ram_addr", int'(bus.ram_addr), e.addr);
                chk("ram_wr_data", int'(bus.ram_wr_data), e.data);
            end
        end
    end

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit v, input int d, input bit l, input bit rel);
        bit acc, fire;
        int rb;
        @(negedge clk);
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_stall = 0;
        end
        chk("s_ready", int'(bus.s_ready), int'(m_stall == 0));
        chk("line_valid", int'(bus.line_valid), int'(pend.size() > 0));
        chk("line_bank", int'(bus.line_bank), m_rbank);
        if (pend.size() > 0) chk("line_len", int'(bus.line_len), pend[0].len);
        chk("ovf_err", int'(bus.ovf_err), m_ovf);

        bus.s_valid  = v;
        bus.s_data   = DW'(d);
        bus.s_last   = l;
        bus.line_rel = rel;
        acc  = v && (m_stall == 0);
        fire = rel && (pend.size() > 0);

        if (fire) begin
            rb = pend[0].bank;
            void'(pend.pop_front());
            m_rbank ^= 1;
            if (m_stall != 0 && rb == m_wbank) m_cnt = 2;
        end
        if (acc) begin
            if (m_drop == 0) begin
                exp_wr.push_back('{m_wbank * BANK + m_col, d & ((1 << DW) - 1)});
                if (l) begin
                    pend.push_back('{m_wbank, m_col + 1});
                    m_wbank ^= 1; m_col = 0;
                    if (occupied(m_wbank)) m_stall = 1;
                end else if (m_col == BANK - 1) begin
                    pend.push_back('{m_wbank, BANK});
                    m_ovf = 1; m_wbank ^= 1; m_col = 0; m_drop = 1;
                end else begin
                    m_col++;
                end
            end else if (l) begin
                m_drop = 0;
                if (occupied(m_wbank)) m_stall = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_line(input int n, input int base, input bit rel_on_last);
        for (int i = 0; i < n; i++)
            step(1'b1, base + i, i == n - 1, rel_on_last && (i == n - 1));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.line_rel = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_line_valid", int'(bus.line_valid), 0);
        chk("rst_ovf_err", int'(bus.ovf_err), 0);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_ram_wr_en", int'(bus.ram_wr_en), 0);
        chk("rst_line_len", int'(bus.line_len), 0);
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_pending_writes", exp_wr.size(), 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.line_rel = 1'b0;
        model_reset();
        do_reset(3);

        // four pixels 0x10..0x13 into bank 0
        send_line(4, 16'h10, 1'b0);
        idle(2);
        chk("d036_len", int'(bus.line_len), 4);
        step(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // two lines, no release -> stall; release -> bank 1 presented, ready two cycles later
        do_reset(2);
        send_line(3, 16'h20, 1'b0);
        send_line(5, 16'h30, 1'b0);
        step(1'b1, 16'h55, 1'b0, 1'b0);   // offered while stalled, must not be taken
        idle(3);
        step(1'b0, 0, 1'b0, 1'b1);
        idle(3);
        chk("d037_bank", int'(bus.line_bank), 1);
        chk("d037_len", int'(bus.line_len), 5);
        send_line(2, 16'h40, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // overflow: 1030-pixel line, then a short line into bank 1
        do_reset(2);
        send_line(1030, 0, 1'b0);
        send_line(4, 16'h80, 1'b0);
        idle(2);
        chk("d038_ovf", int'(bus.ovf_err), 1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // release with nothing presented is ignored
        do_reset(2);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // completion of bank 1 in the same cycle as release of bank 0: no stall
        send_line(2, 16'h60, 1'b0);
        send_line(3, 16'h70, 1'b1);
        send_line(2, 16'h90, 1'b0);
        idle(2);

        // reset mid-line after 7 pixels, then the next pixel goes to address 0
        do_reset(2);
        for (int i = 0; i < 7; i++) step(1'b1, 16'hA0 + i, 1'b0, 1'b0);
        do_reset(2);
        send_line(3, 16'hB0, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                step($urandom_range(0, 99) < 75, int'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30);
            end
        end

        idle(4);
        chk("writes_drained", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
